// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB over one memory port
module multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic             legal;
  logic             waiting;
  logic             to_hit;
  logic             unused_funct3;

  // Store size is resolved in the datapath; the sequencer never looks at it.
  assign unused_funct3 = ^funct3;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_REG, OP_IMM, OP_LUI, OP_AUIPC: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Trap on the cycle whose wait would bring the count up to TIMEOUT; a ready in that cycle still wins.
  assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
  assign to_hit  = (TIMEOUT != 0) && waiting && (wait_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    retire       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = branch_taken;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            reg_we  = 1'b1;
            pc_we   = 1'b1;
            pc_src  = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_LOAD, OP_STORE:               state_d = S_MEM;
          OP_REG, OP_IMM, OP_LUI, OP_AUIPC: state_d = S_WB;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (opcode == OP_LOAD);
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    // Strobes drop as soon as reset asserts, abandoning any in-flight transfer.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 1'b0;
      retire       = 1'b0;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting) begin
      wait_d = wait_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      wait_q    <= '0;
      cause_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign instret    = instret_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl against a latency/strobe model
module tb_multicycle_ctrl;

  localparam logic [4:0] LD = 5'b00000, IMM = 5'b00100, AUIPC = 5'b00101, ST = 5'b01000;
  localparam logic [4:0] REG = 5'b01100, LUI = 5'b01101, BR = 5'b11000, JALR = 5'b11001, JAL = 5'b11011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] opcode = 5'b0;
  logic [2:0] funct3 = 3'b0;
  logic branch_taken = 1'b0;
  logic mem_ready = 1'b0;

  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel, retire, trap;
  logic [3:0] instret;
  logic [1:0] trap_cause;

  logic nt_mem_req, nt_mem_we, nt_mem_addr_sel, nt_ir_we, nt_pc_we, nt_pc_src;
  logic nt_reg_we, nt_wb_sel, nt_retire, nt_trap;
  logic [31:0] nt_instret;
  logic [1:0] nt_trap_cause;

  int n_checks = 0;
  int n_fail = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(4), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel),
    .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  multicycle_ctrl #(.CNT_W(32), .TIMEOUT(0), .TO_W(8)) dut_nt (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(nt_mem_req), .mem_we(nt_mem_we), .mem_addr_sel(nt_mem_addr_sel),
    .ir_we(nt_ir_we), .pc_we(nt_pc_we), .pc_src(nt_pc_src), .reg_we(nt_reg_we), .wb_sel(nt_wb_sel),
    .retire(nt_retire), .instret(nt_instret), .trap(nt_trap), .trap_cause(nt_trap_cause)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_nt_mem_req", 32'(nt_mem_req), 32'd0);
    @(posedge clk);
    #2;
    chk("rst_trap", {30'd0, trap, 1'b0} | 32'(trap_cause), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_nt_instret", nt_instret, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_fetch", {30'd0, mem_req, mem_addr_sel}, 32'b10);
    model_cnt = 0;
  endtask

  // Expected strobes derive from the per-class latency rules: F fetch cycles, decode, exec, M mem cycles, wb.
  task automatic run_instr(input logic [4:0] op, input int fw, input int mw, input logic taken);
    int f, m, n;
    logic is_ld, is_st, is_br, is_j, is_alu, in_f, in_m;
    logic [6:0] exp_v, got_v;
    is_ld  = (op == LD);
    is_st  = (op == ST);
    is_br  = (op == BR);
    is_j   = (op == JAL) || (op == JALR);
    is_alu = (op == REG) || (op == IMM) || (op == LUI) || (op == AUIPC);
    f = fw + 1;
    m = mw + 1;
    n = (is_br || is_j) ? f + 2 : is_alu ? f + 3 : is_st ? f + 2 + m : f + 3 + m;
    for (int k = 1; k <= n; k++) begin
      in_f = (k <= f);
      in_m = (is_ld || is_st) && (k >= f + 3) && (k <= f + 2 + m);
      opcode = in_f ? 5'($urandom) : op;
      funct3 = 3'($urandom);
      branch_taken = (k == f + 2) ? taken : 1'($urandom);
      mem_ready = in_f ? (k == f) : in_m ? (k == f + 2 + m) : 1'($urandom);
      #1;
      exp_v = {in_f || in_m, in_m, in_m && is_st, k == f, k == n, (k == n) && !is_br && !is_st, k == n};
      got_v = {mem_req, mem_addr_sel, mem_we, ir_we, pc_we, reg_we, retire};
      chk($sformatf("strobes op=%b k=%0d", op, k), 32'(got_v), 32'(exp_v));
      chk($sformatf("nt_retire op=%b k=%0d", op, k), 32'(nt_retire), 32'(k == n));
      chk("no_trap", 32'(trap), 32'd0);
      if (k == n) begin
        chk($sformatf("pc_src op=%b", op), 32'(pc_src), 32'(is_br ? taken : is_j));
        chk($sformatf("wb_sel op=%b", op), 32'(wb_sel), 32'(is_ld));
      end
      @(posedge clk);
      #1;
    end
    model_cnt++;
    chk("instret", 32'(instret), 32'(model_cnt % 16));
    chk("nt_instret", nt_instret, 32'(model_cnt));
  endtask

  initial begin
    logic [4:0] legal_ops [9];
    legal_ops = '{LD, ST, BR, JAL, JALR, REG, IMM, LUI, AUIPC};

    do_reset();

    run_instr(IMM, 0, 0, 1'b0);
    run_instr(REG, 0, 0, 1'b0);
    chk("two_alu_instret", 32'(instret), 32'd2);

    run_instr(LD, 0, 3, 1'b0);
    run_instr(BR, 0, 0, 1'b1);
    run_instr(BR, 0, 0, 1'b0);
    run_instr(ST, 1, 2, 1'b0);
    run_instr(JAL, 3, 0, 1'b0);
    run_instr(LD, 3, 3, 1'b0);

    // Illegal opcode: trap in DECODE, then nothing moves until reset.
    do_reset();
    run_instr(IMM, 0, 0, 1'b0);
    opcode = 5'($urandom);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    opcode = 5'b11111;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("illegal_trap", 32'(trap), 32'd1);
    chk("illegal_cause", 32'(trap_cause), 32'b01);
    chk("nt_illegal_cause", 32'(nt_trap_cause), 32'b01);
    for (int i = 0; i < 6; i++) begin
      opcode = 5'($urandom);
      mem_ready = 1'($urandom);
      branch_taken = 1'($urandom);
      #1;
      chk("trap_quiet", {29'd0, mem_req, retire, trap}, 32'b001);
      chk("trap_instret", 32'(instret), 32'd1);
      @(posedge clk);
      #1;
    end
    do_reset();

    // Fetch timeout: four unanswered request cycles, then trap with cause 10.
    for (int k = 1; k <= 4; k++) begin
      mem_ready = 1'b0;
      #1;
      chk($sformatf("to_req k=%0d", k), 32'(mem_req), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("to_trap", 32'(trap), 32'd1);
    chk("to_cause", 32'(trap_cause), 32'b10);
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("nt_no_timeout", {30'd0, nt_trap, nt_mem_req}, 32'b01);
    do_reset();

    // Counter wrap at CNT_W = 4.
    for (int i = 0; i < 17; i++) run_instr(IMM, 0, 0, 1'b0);
    chk("wrap_instret", 32'(instret), 32'd1);
    chk("nt_17_instret", nt_instret, 32'd17);

    // Reset in the middle of a load's MEM phase.
    opcode = LD;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    #1;
    chk("mid_mem_req", {30'd0, mem_req, mem_addr_sel}, 32'b11);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_drop", {30'd0, mem_req, nt_mem_req}, 32'd0);
    chk("mid_rst_instret", 32'(instret), 32'd0);
    chk("mid_rst_nt_instret", nt_instret, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_fetch", {30'd0, mem_req, mem_addr_sel}, 32'b10);
    model_cnt = 0;
    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < 40; i++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle sequencer for the RV32I core. Drives the instruction decoder and its datapath through FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a req/ready handshake.
- Owns every write enable: IR, PC and register file. The decoder still owns the mux selects and aluop.
- Counts retired instructions. Traps on illegal opcodes and on memory timeouts.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- TIMEOUT, 0: maximum wait cycles on a memory request before a bus trap; 0 disables the timeout.
- TO_W, 8: width of the wait counter; TIMEOUT must be < 2^TO_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  5  instr[6:2] from the instruction register.
- funct3  input  3  instr[14:12]; selects store size only, passed through.
- branch_taken  input  1  branch comparator result, valid in EXEC.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request valid.
- mem_we  output  1  request is a write (store).
- mem_addr_sel  output  1  0 = PC (fetch), 1 = ALU result (load/store).
- ir_we  output  1  latch mem_rdata into the instruction register.
- pc_we  output  1  update PC this cycle.
- pc_src  output  1  0 = PC+4, 1 = ALU result.
- reg_we  output  1  register file write strobe.
- wb_sel  output  1  0 = ALU/PC path (per decoder regmux), 1 = load data.
- retire  output  1  one-cycle pulse when an instruction completes.
- instret  output  CNT_W  retired-instruction count.
- trap  output  1  sticky: core halted.
- trap_cause  output  2  01 = illegal opcode, 10 = memory timeout, 00 = none.

Behaviour:
- Reset (asynchronous): state = FETCH, instret = 0, trap = 0, trap_cause = 00, wait counter = 0. All strobes are combinational from state and are 0 outside their states. In FETCH under reset, mem_req = 1 once rst deasserts.
- Handshake:
  - A transfer completes on a rising edge where mem_req & mem_ready.
  - mem_req, mem_we and mem_addr_sel hold steady until completion.
  - mem_ready while mem_req = 0 is ignored.
- FETCH: mem_req = 1, mem_addr_sel = 0. ir_we = mem_ready (Mealy). On completion go to DECODE.
- DECODE: one cycle, no strobes. Legal opcodes are LOAD, STORE, BRANCH, JAL, JALR, REG, IMM, LUI, AUIPC. Legal -> EXEC. Otherwise -> TRAP with cause 01.
- EXEC:
  - BRANCH: pc_we = 1, pc_src = branch_taken, retire -> FETCH.
  - JAL/JALR: reg_we = 1, wb_sel = 0, pc_we = 1, pc_src = 1, retire -> FETCH.
  - LOAD/STORE: -> MEM.
  - REG/IMM/LUI/AUIPC: -> WB.
- MEM: mem_req = 1, mem_addr_sel = 1, mem_we = (opcode == STORE). On completion:
  - store: pc_we = 1, pc_src = 0, retire -> FETCH.
  - load: -> WB.
- WB: reg_we = 1, wb_sel = (opcode == LOAD), pc_we = 1, pc_src = 0, retire -> FETCH.
- TRAP: terminal state. All strobes 0, instret frozen. Only reset exits.
- Latency with zero wait states:
  - branch, jump: 3 cycles.
  - ALU, LUI, AUIPC, store: 4 cycles.
  - load: 5 cycles.
  - Each memory wait cycle adds 1.
- instret:
  - Increments by 1 on every retire and wraps modulo 2^CNT_W.
  - Retire counts exactly once per instruction, including x0-destination writes.
- Timeout (TIMEOUT > 0):
  - The wait counter clears on entering FETCH/MEM and increments each cycle mem_req & !mem_ready.
  - When the count reaches TIMEOUT with no ready, the next edge goes to TRAP with cause 10, and mem_req drops.
  - mem_ready arriving on the same cycle the count reaches TIMEOUT wins: the transfer completes, no trap.
- Opcode and branch_taken are sampled only in DECODE/EXEC/MEM/WB. Changes elsewhere have no effect.
- Reset asserted mid-request: mem_req drops asynchronously. The in-flight transfer is abandoned and not retired.

Test Plan:
- ADDI then ADD, mem_ready tied 1 -> each takes 4 cycles. retire pulses at cycles 4 and 8. instret = 2. reg_we high exactly in WB.
- LW with mem_ready low for 3 cycles in MEM -> mem_req and mem_addr_sel = 1 stable for 4 cycles. WB has wb_sel = 1. Total 8 cycles. Exactly one retire.
- BEQ with branch_taken = 1, then with branch_taken = 0 -> 3 cycles each. pc_src = 1 then 0. reg_we never asserted.
- Opcode 5'b11111 fetched -> DECODE goes to TRAP. trap = 1, trap_cause = 01, instret unchanged, no further mem_req. rst clears everything.
- TIMEOUT = 4, mem_ready held 0 in FETCH -> trap with cause 10 after 4 wait cycles. Repeat with ready on the 4th cycle -> no trap, DECODE follows.
- CNT_W = 4, run 17 single-cycle-ready ADDIs -> instret = 1 (wraps). Assert rst mid-MEM -> instret = 0, state FETCH, mem_req low during reset.
